// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: captures PC and instruction and pre-decodes rs/rt/immediates.
// Define IF_ID_SKID_EN to add a skid entry that keeps in_ready a registered output.
module if_id_pipe #(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int REG_W    = 5,
  parameter int SRC1_LSB = 21,
  parameter int SRC2_LSB = 16,
  parameter int IMM_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [INST_W-1:0] out_imm_sx,
  output logic [INST_W-1:0] out_imm_zx,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [INST_W-1:0] imm_sx;
    logic [INST_W-1:0] imm_zx;
  } entry_t;

  // Fields are extracted once at capture so ID sees them straight from flops.
  function automatic entry_t decode(input logic [ADDR_W-1:0] pc,
                                    input logic [INST_W-1:0] inst);
    entry_t e;
    e.pc     = pc;
    e.inst   = inst;
    e.rs     = inst[SRC1_LSB +: REG_W];
    e.rt     = inst[SRC2_LSB +: REG_W];
    e.imm_sx = {{(INST_W-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
    e.imm_zx = {{(INST_W-IMM_W){1'b0}}, inst[IMM_W-1:0]};
    return e;
  endfunction

  entry_t main_q;
  logic   main_valid;
  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;

  assign in_entry = decode(in_pc, in_inst);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

`ifdef IF_ID_SKID_EN
  entry_t skid_q;
  logic   skid_valid;
  logic   ready_q;

  // The skid only fills while main is held, so ready_q always equals !skid_valid
  // and an input transfer never coincides with a full skid.
  always_ff @(posedge clk) begin
    // NOTE: payload flops are cleared too because the ID outputs must read zero after rst/flush.
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      ready_q    <= 1'b1;
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_q     <= in_entry;
      end else begin
        main_valid <= 1'b0;
      end
      ready_q <= 1'b1;
    end else if (in_xfer) begin
      if (!main_valid) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= in_entry;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end
  end

  assign in_ready  = ready_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else if (in_xfer) begin
      main_q     <= in_entry;
      main_valid <= 1'b1;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end

  assign in_ready  = out_ready || !main_valid;
  assign occupancy = {1'b0, main_valid};
`endif

  assign out_valid  = main_valid;
  assign out_pc     = main_q.pc;
  assign out_inst   = main_q.inst;
  assign out_rs     = main_q.rs;
  assign out_rt     = main_q.rt;
  assign out_imm_sx = main_q.imm_sx;
  assign out_imm_zx = main_q.imm_zx;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe; expectations follow the build selected by IF_ID_SKID_EN.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [31:0] out_imm_sx;
  logic [31:0] out_imm_zx;
  logic [1:0]  occupancy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_imm_sx (out_imm_sx),
    .out_imm_zx (out_imm_zx),
    .occupancy  (occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h44; in_inst = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    vectors++;
    if ({out_pc, out_inst, out_rs, out_rt, out_imm_sx, out_imm_zx} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got pc=%h inst=%h rs=%0d rt=%0d sx=%h zx=%h want all 0",
               out_pc, out_inst, out_rs, out_rt, out_imm_sx, out_imm_zx);
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h10; in_inst = 32'h2022_FFFC;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL dec_valid: got %b want 1", out_valid); end
    vectors++; if (out_pc !== 32'h10) begin miscompares++; $display("FAIL dec_pc: got %h want 00000010", out_pc); end
    vectors++; if (out_inst !== 32'h2022_FFFC) begin miscompares++; $display("FAIL dec_inst: got %h want 2022fffc", out_inst); end
    vectors++; if (out_rs !== 5'd1) begin miscompares++; $display("FAIL dec_rs: got %0d want 1", out_rs); end
    vectors++; if (out_rt !== 5'd2) begin miscompares++; $display("FAIL dec_rt: got %0d want 2", out_rt); end
    vectors++; if (out_imm_sx !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL dec_sx: got %h want fffffffc", out_imm_sx); end
    vectors++; if (out_imm_zx !== 32'h0000_FFFC) begin miscompares++; $display("FAIL dec_zx: got %h want 0000fffc", out_imm_zx); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    vectors++; if (out_pc !== 32'h10) begin miscompares++; $display("FAIL hold_pc: got %h want 00000010", out_pc); end
    vectors++; if (out_imm_sx !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL hold_sx: got %h want fffffffc", out_imm_sx); end
    // positive immediate, extreme register indices
    in_valid = 1'b1; in_pc = 32'h14; in_inst = 32'h03E0_7FFF;
    step();
    in_valid = 1'b0;
    vectors++; if (out_rs !== 5'd31) begin miscompares++; $display("FAIL dec2_rs: got %0d want 31", out_rs); end
    vectors++; if (out_rt !== 5'd0) begin miscompares++; $display("FAIL dec2_rt: got %0d want 0", out_rt); end
    vectors++; if (out_imm_sx !== 32'h0000_7FFF) begin miscompares++; $display("FAIL dec2_sx: got %h want 00007fff", out_imm_sx); end
    vectors++; if (out_imm_zx !== 32'h0000_7FFF) begin miscompares++; $display("FAIL dec2_zx: got %h want 00007fff", out_imm_zx); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_inst = 32'h100 + 32'(i);
      step();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_pc !== 32'(4 * i)) begin miscompares++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL b2b_occ[%0d]: got %0d want 1", i, occupancy); end
    end
    in_valid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", out_valid); end
  endtask

`ifdef IF_ID_SKID_EN
  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'hA0;
    step();
    in_pc = 32'h4; in_inst = 32'hA4;
    step();
    in_pc = 32'h8; in_inst = 32'hA8;
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL stall_occ: got %0d want 2", occupancy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    step();
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL stall_pc: got %h want 0", out_pc); end
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL stall_occ2: got %0d want 2", occupancy); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    vectors++; if (out_pc !== 32'h4) begin miscompares++; $display("FAIL release_pc: got %h want 4", out_pc); end
    vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL release_occ: got %0d want 1", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_end: got %b want 0 (pc %h)", out_valid, out_pc); end
  endtask

  task automatic fill_stalled();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'hB0;
    step();
    in_pc = 32'h4; in_inst = 32'hB4;
    step();
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL fill_occ: got %0d want 2", occupancy); end
  endtask
`else
  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'hA0;
    step();
    in_pc = 32'h4; in_inst = 32'hA4;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    step();
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL stall_pc: got %h want 0", out_pc); end
    vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL stall_occ: got %0d want 1", occupancy); end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL comb_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_pc !== 32'h4) begin miscompares++; $display("FAIL release_pc: got %h want 4", out_pc); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL release_valid: got %b want 1", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_end: got %b want 0", out_valid); end
  endtask

  task automatic fill_stalled();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'hB0;
    step();
    in_pc = 32'h4; in_inst = 32'hB4;
    vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL fill_occ: got %0d want 1", occupancy); end
  endtask
`endif

  task automatic test_flush();
    fill_stalled();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h20; in_inst = 32'hC0;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    vectors++; if ({out_pc, out_inst, out_imm_zx} !== '0) begin miscompares++; $display("FAIL flush_payload: got pc=%h inst=%h zx=%h want 0", out_pc, out_inst, out_imm_zx); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ghost[%0d]: got valid pc=%h want none", i, out_pc); end
    end
  endtask

  task automatic test_reset_midstall();
    fill_stalled();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL rst_stall_occ: got %0d want 0", occupancy); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL rst_stall_pc: got %h want 0", out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ghost[%0d]: got valid pc=%h want none", i, out_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter ADDR_W, 32, PC width in bits.
REQ-002 Parameter INST_W, 32, instruction width in bits.
REQ-003 Parameter REG_W, 5, register-index field width.
REQ-004 Parameter SRC1_LSB, 21, LSB of source-1 index field in instruction.
REQ-005 Parameter SRC2_LSB, 16, LSB of source-2 index field in instruction.
REQ-006 Parameter IMM_W, 16, immediate field width (field at bits IMM_W-1:0).
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 flush  in  1  discard all held and incoming instructions (branch redirect).
REQ-010 in_valid  in  1  IF presents instruction.
REQ-011 in_ready  out  1  stage accepts instruction this cycle.
REQ-012 in_pc  in  ADDR_W  fetch PC.
REQ-013 in_inst  in  INST_W  fetched instruction.
REQ-014 out_valid  out  1  ID-side entry valid.
REQ-015 out_ready  in  1  ID consumes entry this cycle.
REQ-016 out_pc, out_inst  out  ADDR_W, INST_W  registered PC/instruction.
REQ-017 out_rs, out_rt  out  REG_W  index fields at SRC1_LSB, SRC2_LSB.
REQ-018 out_imm_sx, out_imm_zx  out  INST_W  immediate sign-/zero-extended to INST_W.
REQ-019 occupancy  out  2  entries held (0..2).

Function
REQ-020 Input transfer SHALL occur iff in_valid && in_ready at rising edge; output transfer iff out_valid && out_ready.
REQ-021 Field extraction (rs, rt, imm_sx, imm_zx) SHALL be computed at capture and registered with the entry; latency in->out one cycle when empty.
REQ-022 Storage SHALL be a main register (drives outputs) plus one skid register; entries leave in arrival order.
REQ-023 in_ready SHALL be a register output: 1 iff skid register empty after the edge.
REQ-024 Capture while main empty or main draining SHALL load main; capture while main held (out_ready=0) SHALL load skid.
REQ-025 When main drains and skid full, skid SHALL move to main the same edge and skid becomes empty.
REQ-026 Simultaneous output transfer and input transfer with skid empty SHALL yield occupancy unchanged (full throughput, one instr/cycle).
REQ-027 occupancy SHALL equal main_valid + skid_valid; value 3 unreachable.
REQ-028 flush=1 SHALL clear both entries at the edge: out_valid=0, occupancy=0, in_ready=1 next cycle; in_valid same cycle is dropped; all payload outputs zero.
REQ-029 flush SHALL override any simultaneous transfer; flush and rst together behave as rst.
REQ-030 While out_valid=0 and no flush/rst, payload outputs SHALL hold last values.
REQ-031 While out_valid=1 and out_ready=0, outputs SHALL remain stable.

Reset
REQ-032 On rst: out_valid=0, occupancy=0, in_ready=1 next cycle; out_pc, out_inst, out_rs, out_rt, out_imm_sx, out_imm_zx all zero; skid cleared.
REQ-033 rst mid-stall SHALL discard both entries; no entry reappears afterward.

Configuration
REQ-034 Macro IF_ID_SKID_EN defined: skid register and behaviour of REQ-022..026 present.
REQ-035 IF_ID_SKID_EN undefined: no skid register; in_ready = out_ready || !out_valid (combinational); occupancy max 1; all other requirements unchanged.

Verification
REQ-036 rst one cycle, then idle -> out_valid=0, in_ready=1, occupancy=0, all payloads 0.
REQ-037 in_inst=0x2022FFFC, in_pc=0x00000010, out_ready=1 -> next cycle out_rs=1, out_rt=2, out_imm_sx=0xFFFFFFFC, out_imm_zx=0x0000FFFC, out_pc=0x10.
REQ-038 Stream PCs 0x0,0x4,0x8,0xC back-to-back, out_ready=1 -> four consecutive out_valid cycles, in order, in_ready stays 1.
REQ-039 out_ready=0 with PCs 0x0,0x4 pushed -> occupancy=2, in_ready=0, out_pc=0x0 stable; release out_ready -> 0x0 then 0x4, no loss/duplication (skid build).
REQ-040 occupancy=2 then flush with in_valid=1 (PC 0x20) -> next cycle out_valid=0, occupancy=0, PC 0x20 never emitted.
REQ-041 IF_ID_SKID_EN undefined, out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
